// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end: default datapath
// width and reset PC, the canonical NOP encoding presented to decode when no
// instruction is available, and the {pc, instr} record held in the prefetch
// buffer.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_if
// Bundles the fetch unit's external signals:
//   imem_req / imem_addr / imem_rdata : synchronous instruction-memory read port
//   br_taken / br_target              : redirect from execute
//   id_valid / id_ready / id_pc / id_instr : head of prefetch buffer to decode
//   pc_out                            : current fetch PC
// Modports:
//   master : the fetch unit
//   slave  : its environment (memory, execute, decode)
// -----------------------------------------------------------------------------
interface fetch_prefetch_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 10
);

    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    logic               br_taken;
    logic [XLEN-1:0]    br_target;

    logic               id_valid;
    logic               id_ready;
    logic [XLEN-1:0]    id_pc;
    logic [31:0]        id_instr;

    logic [XLEN-1:0]    pc_out;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  br_taken, br_target,
        output id_valid,
        input  id_ready,
        output id_pc, id_instr, pc_out
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output br_taken, br_target,
        input  id_valid,
        output id_ready,
        input  id_pc, id_instr, pc_out
    );

endinterface

// File: rtl/fetch_fifo2.sv
// -----------------------------------------------------------------------------
// fetch_fifo2
// Two-entry FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail this cycle
//   pop        : drop the head this cycle (ignored when empty)
//   flush      : discard all entries; overrides push and pop
//   push_data  : entry to write
//   head       : oldest entry (meaningful only when count != 0)
//   count      : number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_fifo2
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        do_pop  = pop & (count != 2'd0);
        do_push = push & ~flush;
    end

    // NOTE: the storage array has no reset; an entry is only visible through
    // head once count says it was written, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = slots[rd_ptr];

    // The issue rule upstream keeps at most two entries owed to this buffer.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) !(do_push && count == 2'd2)
    );

endmodule

// File: rtl/fetch_prefetch.sv
// -----------------------------------------------------------------------------
// fetch_prefetch
// Instruction-fetch front end. Owns the PC, issues one-word reads to the
// synchronous instruction memory, buffers returned words in a 2-entry
// prefetch FIFO and presents the head {pc, instr} to decode with valid/ready.
// A taken-branch redirect reloads the PC and discards everything fetched but
// not yet consumed, including a response still in flight.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_prefetch_if.master (imem port, redirect, decode handshake,
//              pc_out)
// -----------------------------------------------------------------------------
module fetch_prefetch #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              IMEM_AW  = 10,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    fetch_prefetch_if.master  bus
);

    import fetch_pkg::*;

    logic [XLEN-1:0] pc;        // next address to request
    logic [XLEN-1:0] req_pc;    // address of the outstanding request
    logic            inflight;  // a response arrives on imem_rdata this cycle
    logic [1:0]      count;
    logic [2:0]      occupancy;
    logic            id_valid;
    logic            pop;
    logic            push;
    logic            issue;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // NOTE: every signal in this block is assigned on every path, so no
    // latch can be inferred.
    always_comb begin
        id_valid   = (count != 2'd0);
        pop        = id_valid & bus.id_ready;
        // Entries owed to the buffer after this cycle; a pop implies count >= 1,
        // so this never underflows.
        occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue      = ~rst & ~bus.br_taken & (occupancy < 3'd2);
        // A redirect drops the response that lands in the same cycle.
        push       = inflight & ~bus.br_taken;
        push_entry = '{pc: req_pc, instr: bus.imem_rdata};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (bus.br_taken) begin
            pc       <= {bus.br_target[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + XLEN'(4);
                req_pc <= pc;
            end
        end
    end

    fetch_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.br_taken),
        .push_data (push_entry),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc[IMEM_AW+1:2];
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = id_valid ? head.pc : '0;
    assign bus.id_instr  = id_valid ? head.instr : NOP_INSTR;
    assign bus.pc_out    = pc;

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction-fetch front end for the 5-stage core: owns the program counter, issues word reads to the synchronous instruction memory, and holds returned instructions in a 2-entry prefetch buffer. It presents {pc, instr} to decode through a valid/ready handshake. It accepts a taken-branch redirect from execute, which flushes all fetched-but-unconsumed state. It sits between instruction memory and the IF/ID boundary, upstream of decode/register read.

## Interface
- XLEN, 32, PC and instruction width
- IMEM_AW, 10, instruction memory word-address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset: asynchronous, active-high (polarity and synchronicity fixed)
- imem_req  out  1  read request this cycle
- imem_addr  out  IMEM_AW  word address, = pc[IMEM_AW+1:2]
- imem_rdata  in  32  read data, valid the cycle after imem_req
- br_taken  in  1  redirect from execute (single-cycle pulse)
- br_target  in  XLEN  redirect byte address
- id_valid  out  1  buffer head valid
- id_ready  in  1  decode accepts head this cycle
- id_pc  out  XLEN  PC of head entry
- id_instr  out  32  instruction of head entry; NOP (32'h0000_0013) when id_valid=0
- pc_out  out  XLEN  current fetch PC

## Operation
- State: pc, inflight flag (1 request outstanding), FIFO of 2 entries {pc, instr}, count 0..2.
- pop = id_valid & id_ready.
- Issue rule: imem_req = ~br_taken & (count + inflight - pop < 2). On issue, pc <= pc + 4 (modulo 2^XLEN) and inflight <= 1; else inflight <= 0.
- Response: when inflight=1 in a cycle, push {pc_of_request, imem_rdata} into the FIFO at the end of that cycle. The issue rule guarantees the FIFO never overflows; push to a full FIFO is an assertion failure.
- Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (br_taken=1): pc <= {br_target[XLEN-1:2], 2'b00}. FIFO cleared, count <= 0, inflight <= 0 so any outstanding response is dropped. No request is issued that cycle; fetch resumes at the target the next cycle. br_taken overrides a simultaneous pop; whether decode treats a pop in that cycle as consumed is its own concern.
- The FIFO is empty and no request is issued while br_taken is asserted on consecutive cycles; the last target wins.

## Timing
- Reset values: pc=RESET_PC, pc_out=RESET_PC, count=0, inflight=0, id_valid=0, id_pc=0, id_instr=NOP, imem_req=0.
- Reset assertion clears all state immediately, including mid-fetch and mid-redirect. The first imem_req=1 (addr RESET_PC>>2) occurs in the first cycle after rst deasserts.
- Fetch latency: request in cycle N, rdata sampled in N+1, id_valid=1 in N+2.
- Redirect penalty: br_taken in cycle R, target request in R+1, target id_valid in R+3.
- Steady state with id_ready held high: 1 instruction per cycle.
- With id_ready=0: the FIFO fills to 2 and imem_req drops to 0. The head is stable: id_pc and id_instr must not change while id_valid=1 and id_ready=0.

## Structure
- Shared package fetch_pkg:
  - XLEN and RESET_PC defaults
  - NOP_INSTR = 32'h0000_0013
  - typedef fetch_entry_t struct {pc, instr}
- Sub-module fetch_fifo2: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and head outputs.
- Top-level logic (PC, issue rule, inflight tracking) lives in fetch_prefetch.

## Test plan
- Reset, id_ready=1, imem preloaded with word i = i: id_valid first high 3 cycles after reset release; then (id_pc, id_instr) = (0,0), (4,1), (8,2)… on consecutive cycles.
- id_ready=0 from cycle 3 to 10: count stays 2, imem_req=0 after fill, head stays (0,0). Release id_ready: stream resumes in order with no gap or duplicate.
- br_taken with br_target=0x40 while FIFO full and a request in flight: FIFO empties next cycle, first id_pc after the redirect = 0x40, 3 cycles after br_taken. No pre-redirect PC is ever presented afterwards.
- br_target=0x43: fetch resumes at 0x40.
- Redirect coincident with pop, and br_taken on 2 consecutive cycles (0x80 then 0x100): only 0x100 stream appears.
- Assert rst mid-stream for 1 cycle: all outputs return to reset values that cycle. Restart fetch at RESET_PC; pc wraps correctly when RESET_PC = 0xFFFF_FFFC (next PC 0).
